// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM (Moore): sequences fetch/decode/execute and drives datapath selects.
// Optional macro MULTICYCLE_BNE_EN adds bne (funct3=001) to the branch path; default build supports beq only.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic [2:0] ALUControl,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       Illegal,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } aluop_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t     r_state;
   state_t     w_cur;
   state_t     w_next;
   aluop_t     w_aluop;
   logic       w_irwrite;
   logic       w_pcupdate;
   logic       w_branch;
   logic       w_regwrite;
   logic       w_memwrite;
   logic       w_illegal;
   logic       w_branch_ok;
   logic       w_taken;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Reset presents Fetch selects immediately; write enables are masked below.
   assign w_cur = reset ? S_FETCH : r_state;
   assign State = w_cur;

`ifdef MULTICYCLE_BNE_EN
   assign w_branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
   assign w_taken     = (funct3 == 3'b000) ? Zero :
                        (funct3 == 3'b001) ? ~Zero : 1'b0;
`else
   assign w_branch_ok = (funct3 == 3'b000);
   assign w_taken     = (funct3 == 3'b000) ? Zero : 1'b0;
`endif

   always_comb begin
      w_next     = S_FETCH;
      w_aluop    = ALUOP_ADD;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      AdrSrc     = 1'b0;
      w_irwrite  = 1'b0;
      w_pcupdate = 1'b0;
      w_branch   = 1'b0;
      w_regwrite = 1'b0;
      w_memwrite = 1'b0;
      w_illegal  = 1'b0;
      case (w_cur)
         S_FETCH: begin
            AdrSrc     = 1'b0;
            w_irwrite  = 1'b1;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            w_pcupdate = 1'b1;
            w_next     = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_RTYPE:          w_next = S_EXECR;
               OP_ITYPE:          w_next = S_EXECI;
               OP_JAL:            w_next = S_JAL;
               OP_BRANCH: begin
                  if (w_branch_ok) begin
                     w_next = S_BEQ;
                  end else begin
                     w_illegal = 1'b1;
                  end
               end
               default:           w_illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            w_next  = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            w_next = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            w_regwrite = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            w_memwrite = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b00;
            w_aluop = ALUOP_FUNCT;
            w_next  = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            w_aluop = ALUOP_FUNCT;
            w_next  = S_ALUWB;
         end
         S_ALUWB: begin
            w_regwrite = 1'b1;
         end
         S_JAL: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            w_pcupdate = 1'b1;
            w_next     = S_ALUWB;
         end
         S_BEQ: begin
            ALUSrcA  = 2'b10;
            ALUSrcB  = 2'b00;
            w_aluop  = ALUOP_SUB;
            w_branch = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   always_comb begin
      ALUControl = 3'b000;
      case (w_aluop)
         ALUOP_SUB: ALUControl = 3'b001;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      case (op)
         OP_LOAD, OP_ITYPE: ImmSrc = 2'b00;
         OP_STORE:          ImmSrc = 2'b01;
         OP_BRANCH:         ImmSrc = 2'b10;
         OP_JAL:            ImmSrc = 2'b11;
         default:           ImmSrc = 2'b00;
      endcase
   end

   assign IRWrite  = ~reset & w_irwrite;
   assign PCWrite  = ~reset & (w_pcupdate | (w_branch & w_taken));
   assign RegWrite = ~reset & w_regwrite;
   assign MemWrite = ~reset & w_memwrite;
   assign Illegal  = ~reset & w_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-cycle expected outputs queued by the driver, compared by a monitor.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic [2:0] ALUControl;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal;
   logic [3:0] State;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
      .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .Illegal(Illegal), .State(State)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic [2:0] aluc;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [1:0] res;
      logic [1:0] imm;
      logic       adr;
      logic       irw;
      logic       pcw;
      logic       rgw;
      logic       mw;
      logic       ill;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   pushed = 0;
   int   popped = 0;

   // Instruction classes: 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 branch, 6 illegal
   function automatic int cls_of(logic [6:0] o, logic [2:0] f3);
      case (o)
         7'b0000011: return 0;
         7'b0100011: return 1;
         7'b0110011: return 2;
         7'b0010011: return 3;
         7'b1101111: return 4;
         7'b1100011: begin
`ifdef MULTICYCLE_BNE_EN
            if (f3 == 3'd0 || f3 == 3'd1) return 5;
`else
            if (f3 == 3'd0) return 5;
`endif
            return 6;
         end
         default: return 6;
      endcase
   endfunction

   function automatic logic [1:0] imm_of(logic [6:0] o);
      if (o == 7'b0100011) return 2'b01;
      if (o == 7'b1100011) return 2'b10;
      if (o == 7'b1101111) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [2:0] funct_alu(logic [6:0] o, logic [2:0] f3, logic f7);
      if (f3 == 3'd0) return (o[5] && f7) ? 3'd1 : 3'd0;
      if (f3 == 3'd2) return 3'd5;
      if (f3 == 3'd6) return 3'd3;
      if (f3 == 3'd7) return 3'd2;
      return 3'd0;
   endfunction

   function automatic logic taken_of(logic [2:0] f3, logic z);
      if (f3 == 3'd0) return z;
`ifdef MULTICYCLE_BNE_EN
      if (f3 == 3'd1) return ~z;
`endif
      return 1'b0;
   endfunction

   function automatic exp_t model(int st, logic rst, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
      exp_t e;
      int   s;
      e = '0;
      s = rst ? 0 : st;
      e.st  = 4'(s);
      e.imm = imm_of(o);
      case (s)
         0:  begin e.irw = 1; e.srcb = 2; e.res = 2; e.pcw = 1; end
         1:  begin e.srca = 1; e.srcb = 1; e.ill = (cls_of(o, f3) == 6); end
         2:  begin e.srca = 2; e.srcb = 1; end
         3:  e.adr = 1;
         4:  begin e.res = 1; e.rgw = 1; end
         5:  begin e.adr = 1; e.mw = 1; end
         6:  begin e.srca = 2; e.aluc = funct_alu(o, f3, f7); end
         7:  begin e.srca = 2; e.srcb = 1; e.aluc = funct_alu(o, f3, f7); end
         8:  e.rgw = 1;
         9:  begin e.srca = 2; e.aluc = 3'd1; e.pcw = taken_of(f3, z); end
         10: begin e.srca = 1; e.srcb = 2; e.pcw = 1; end
         default: e = '0;
      endcase
      if (rst) begin
         e.irw = 0; e.pcw = 0; e.rgw = 0; e.mw = 0; e.ill = 0;
      end
      return e;
   endfunction

   task automatic drive_cycle(int st, logic rst, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
      @(posedge clk);
      #1;
      reset    = rst;
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
      Zero     = z;
      exp_q.push_back(model(st, rst, o, f3, f7, z));
      pushed++;
   endtask

   // zmode: 0/1 fixed Zero, 2 random per cycle. abort_at: cycle index with reset high, -1 for none.
   task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic f7, int zmode, int abort_at);
      int seq[$];
      logic z;
      case (cls_of(o, f3))
         0: seq = '{0, 1, 2, 3, 4};
         1: seq = '{0, 1, 2, 5};
         2: seq = '{0, 1, 6, 8};
         3: seq = '{0, 1, 7, 8};
         4: seq = '{0, 1, 10, 8};
         5: seq = '{0, 1, 9};
         default: seq = '{0, 1};
      endcase
      foreach (seq[i]) begin
         z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         if (i == abort_at) begin
            drive_cycle(seq[i], 1'b1, o, f3, f7, z);
            return;
         end
         drive_cycle(seq[i], 1'b0, o, f3, f7, z);
      end
   endtask

   always @(negedge clk) begin
      exp_t got, e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         popped++;
         got = '{State, ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
                 AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL cycle%0d op=%b f3=%b rst=%b: got st=%0d aluc=%b a=%b b=%b res=%b imm=%b adr=%b irw=%b pcw=%b rgw=%b mw=%b ill=%b, expected st=%0d aluc=%b a=%b b=%b res=%b imm=%b adr=%b irw=%b pcw=%b rgw=%b mw=%b ill=%b",
                     popped, op, funct3, reset,
                     got.st, got.aluc, got.srca, got.srcb, got.res, got.imm, got.adr, got.irw, got.pcw, got.rgw, got.mw, got.ill,
                     e.st, e.aluc, e.srca, e.srcb, e.res, e.imm, e.adr, e.irw, e.pcw, e.rgw, e.mw, e.ill);
         end
      end
   end

   initial begin
      logic [6:0] o;
      logic [2:0] f3;
      int         k;
      // Reset held for two cycles: Fetch selects shown, write enables masked
      drive_cycle(0, 1'b1, 7'b0000011, 3'd0, 1'b0, 1'b0);
      drive_cycle(0, 1'b1, 7'b1101111, 3'd0, 1'b0, 1'b1);
      // Directed cases
      run_instr(7'b0000011, 3'd2, 1'b0, 0, -1);   // lw
      run_instr(7'b0100011, 3'd2, 1'b0, 0, -1);   // sw
      run_instr(7'b0110011, 3'd0, 1'b1, 0, -1);   // sub
      run_instr(7'b0010011, 3'd0, 1'b1, 0, -1);   // addi with funct7b5 set
      run_instr(7'b1100011, 3'd0, 1'b0, 1, -1);   // beq taken
      run_instr(7'b1100011, 3'd0, 1'b0, 0, -1);   // beq not taken
      run_instr(7'b1111111, 3'd0, 1'b0, 0, -1);   // illegal
      run_instr(7'b0000011, 3'd2, 1'b0, 0, 3);    // lw aborted in MemRead
      run_instr(7'b0110011, 3'd7, 1'b0, 0, -1);   // and, after the abort
      run_instr(7'b1100011, 3'd1, 1'b0, 0, -1);   // bne, Zero=0
      run_instr(7'b1101111, 3'd0, 1'b0, 2, -1);   // jal
      run_instr(7'b0110011, 3'd0, 1'b0, 0, 2);    // R aborted in ExecuteR
      // Random instruction stream with occasional mid-instruction resets
      for (int n = 0; n < 400; n++) begin
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 6))
            0: o = 7'b0000011;
            1: o = 7'b0100011;
            2: o = 7'b0110011;
            3: o = 7'b0010011;
            4: o = 7'b1101111;
            5: begin
               o = 7'b1100011;
               if ($urandom_range(0, 1) == 1) f3 = 3'($urandom_range(0, 1));
            end
            default: begin
               o = 7'($urandom_range(0, 127));
               while (cls_of(o, 3'd0) != 6) o = 7'($urandom_range(0, 127));
            end
         endcase
         k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr(o, f3, 1'($urandom_range(0, 1)), 2, k);
      end
      @(posedge clk);
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0 || popped != pushed) begin
         errors++;
         $display("FAIL drain: %0d left in queue, %0d compared, expected %0d compared", exp_q.size(), popped, pushed);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
